pb_edge_multi: RTL and testbench
================================

# pb_edge_multi

Parametrised N-channel push-button / switch conditioner; successor to the single-channel push-button edge debouncer. Each channel synchronises a raw asynchronous input, debounces it with a programmable stability window, and emits one-cycle press, release, long-press and auto-repeat pulses plus a clean level. Sits between board pins (`pb`, `sw`) and control logic such as the serial command block and reset-request logic.

## Interface
- `N_CH`, 4: number of independent channels.
- `SYNC_STAGES`, 2: synchroniser flops per channel, minimum 2.
- `DEB_CYC`, 1000000: consecutive stable samples required to accept a level change, minimum 1.
- `LONG_CYC`, 100000000: cycles held after `prss` before the `lng` pulse, minimum 1.
- `REP_CYC`, 25000000: auto-repeat period after `lng`; 0 disables repeat.
- `ACTIVE_LOW`, 0: 1 means a raw input of 0 is "pressed".
- `clk`  in  1  common clock.
- `rst`  in  1  synchronous, active-high reset.
- `pb`  in  N_CH  raw asynchronous button inputs.
- `level`  out  N_CH  debounced pressed state, 1 = pressed.
- `prss`  out  N_CH  one-cycle pulse on accepted press.
- `rls`  out  N_CH  one-cycle pulse on accepted release.
- `lng`  out  N_CH  one-cycle pulse when the hold reaches `LONG_CYC`.
- `rpt`  out  N_CH  one-cycle auto-repeat pulse while held after `lng`.
- `evt_any`  out  1  registered OR of all `prss|rls|lng|rpt` from the previous cycle.

## Operation
- Per channel: optional inversion (`ACTIVE_LOW`), then `SYNC_STAGES`-deep synchroniser, then a 4-state FSM.
- States: IDLE (released, stable); DEB_DN (candidate press); HELD (pressed, stable); DEB_UP (candidate release).
- IDLE: sync=1 -> DEB_DN, debounce counter := 1.
- DEB_DN: sync=0 -> IDLE, no pulse. Counter reaches `DEB_CYC` -> HELD, `prss`=1, `level`=1, hold counter := 0.
- HELD: hold counter increments and saturates. It equals `LONG_CYC` -> `lng`. Thereafter, if `REP_CYC`>0, `rpt` fires every `REP_CYC` cycles. sync=0 -> DEB_UP, debounce counter := 1.
- DEB_UP: hold counter frozen; `lng`/`rpt` suppressed. sync=1 -> HELD, no pulse, hold count resumes. Counter reaches `DEB_CYC` -> IDLE, `rls`=1, `level`=0, hold counter cleared.
- `lng` fires at most once per press. `rpt` never precedes `lng`.
- Channels are fully independent. Simultaneous events on different channels all appear in the same cycle.
- Reset: every output 0, FSM IDLE, all counters 0, synchroniser flops at the released level. A button held through reset is re-debounced and yields a fresh `prss`. No `rls` is generated by reset.

## Timing
- All outputs registered.
- Raw press stable from cycle 0 -> `prss` high in cycle `SYNC_STAGES+DEB_CYC`, for exactly one cycle.
- `lng` exactly `LONG_CYC` cycles after `prss`, excluding any cycles spent in DEB_UP.
- `rpt` pulses at `LONG_CYC + k*REP_CYC` cycles after `prss`, k≥1, under the same exclusion.
- `rls` latency mirrors `prss`: `SYNC_STAGES+DEB_CYC` cycles.
- `evt_any` lags the per-channel pulses by one cycle.
- Debounce counter width: `$clog2(DEB_CYC+1)`.
- Hold counter width: `$clog2(LONG_CYC+REP_CYC+1)`. After `lng`, it wraps within the repeat window and does not overflow.

## Structure
- Package `pb_pkg`: FSM state enum (IDLE, DEB_DN, HELD, DEB_UP; 2-bit encoding) and counter-width helper functions.
- Sub-module `pb_chan`: one channel (synchroniser, FSM, counters). `pb_edge_multi` instantiates it `N_CH` times in a generate loop and builds `evt_any`.

## Test plan
Use N_CH=4, SYNC_STAGES=2, DEB_CYC=4, LONG_CYC=16, REP_CYC=8.
- Clean press on ch0 at cycle 10, held 10 cycles -> `prss[0]` in cycle 16 only, `level[0]`=1; release -> `rls[0]` 6 cycles after release, no `lng`.
- ch1 bounces 1-0-1-0 at 1-cycle spacing, then holds 1 -> no pulse during the bounce; single `prss[1]` 6 cycles after the final rising edge.
- ch2 held 60 cycles -> `lng[2]` 16 cycles after `prss`; `rpt[2]` at +24, +32, +40 ...; one `rls` after release.
- 2-cycle release glitch on ch2 during hold -> no `rls`; `lng` delayed by 2 cycles.
- ch0 and ch3 press in the same cycle -> `prss[0]` and `prss[3]` in the same cycle; `evt_any` high one cycle later.
- `rst` asserted mid-hold on ch1 for 3 cycles, button kept pressed -> all outputs 0 during and after reset, no `rls`, fresh `prss[1]` 6 cycles after reset release; ACTIVE_LOW=1 run repeats scenario 1 with inverted stimulus.

Source files
------------

// File: rtl/pb_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
// Holds the per-channel FSM state encoding and the counter-width functions.
package pb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      DEB_DN = 2'b01,
      HELD   = 2'b10,
      DEB_UP = 2'b11
   } pb_state_e;

   function automatic int deb_width(input int deb_cyc);
      return $clog2(deb_cyc + 1);
   endfunction

   // After lng the hold counter wraps inside the repeat window, so this is its maximum.
   function automatic int hold_width(input int long_cyc, input int rep_cyc);
      return $clog2(long_cyc + rep_cyc + 1);
   endfunction

endpackage

// File: rtl/pb_chan.sv
// One conditioner channel: polarity fix, synchroniser, debounce FSM,
// and hold counter driving registered press/release/long/repeat pulses.
module pb_chan
   import pb_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYC     = 1000000,
   parameter int LONG_CYC    = 100000000,
   parameter int REP_CYC     = 25000000,
   parameter bit ACTIVE_LOW  = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pb,
   output logic level,
   output logic prss,
   output logic rls,
   output logic lng,
   output logic rpt
);

   localparam int DW = deb_width(DEB_CYC);
   localparam int HW = hold_width(LONG_CYC, REP_CYC);

   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC);
   localparam logic [DW-1:0] DEB_ONE  = DW'(1);
   localparam logic [HW-1:0] LONG_V   = HW'(LONG_CYC);
   localparam logic [HW-1:0] LONG_M1  = HW'(LONG_CYC - 1);
   localparam logic [HW-1:0] WRAP_M1  = HW'(LONG_CYC + REP_CYC - 1);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   logic                   pb_act;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   pb_state_e              state;
   logic [DW-1:0]          deb_cnt;
   logic [HW-1:0]          hold_cnt;
   logic [HW-1:0]          hold_nxt;
   logic                   lng_hit;
   logic                   rpt_hit;

   assign pb_act = ACTIVE_LOW ? ~pb : pb;
   assign sync   = sync_q[SYNC_STAGES-1];

   // One held cycle of progress: count to LONG_CYC, then cycle through the repeat window.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      hold_nxt = hold_cnt;
      lng_hit  = 1'b0;
      rpt_hit  = 1'b0;
      if (hold_cnt < LONG_V) begin
         hold_nxt = hold_cnt + HOLD_ONE;
         lng_hit  = (hold_cnt == LONG_M1);
      end else if (REP_CYC > 0) begin
         if (hold_cnt == WRAP_M1) begin
            hold_nxt = LONG_V;
            rpt_hit  = 1'b1;
         end else begin
            hold_nxt = hold_cnt + HOLD_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         state    <= IDLE;
         deb_cnt  <= '0;
         hold_cnt <= '0;
         level    <= 1'b0;
         prss     <= 1'b0;
         rls      <= 1'b0;
         lng      <= 1'b0;
         rpt      <= 1'b0;
      end else begin
         // NOTE: non-blocking so each stage takes its neighbour's old value; blocking would collapse the chain.
         sync_q <= {sync_q[SYNC_STAGES-2:0], pb_act};
         prss   <= 1'b0;
         rls    <= 1'b0;
         lng    <= 1'b0;
         rpt    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (sync) begin
                  state   <= DEB_DN;
                  deb_cnt <= DEB_ONE;
               end
            end
            DEB_DN: begin
               if (!sync) begin
                  state <= IDLE;
               end else if (deb_cnt == DEB_LAST) begin
                  state    <= HELD;
                  prss     <= 1'b1;
                  level    <= 1'b1;
                  hold_cnt <= '0;
               end else begin
                  deb_cnt <= deb_cnt + DEB_ONE;
               end
            end
            HELD: begin
               if (!sync) begin
                  state   <= DEB_UP;
                  deb_cnt <= DEB_ONE;
               end else begin
                  hold_cnt <= hold_nxt;
                  lng      <= lng_hit;
                  rpt      <= rpt_hit;
               end
            end
            DEB_UP: begin
               if (sync) begin
                  state    <= HELD;
                  hold_cnt <= hold_nxt;
                  lng      <= lng_hit;
                  rpt      <= rpt_hit;
               end else if (deb_cnt == DEB_LAST) begin
                  state    <= IDLE;
                  rls      <= 1'b1;
                  level    <= 1'b0;
                  hold_cnt <= '0;
               end else begin
                  deb_cnt <= deb_cnt + DEB_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pb_edge_multi.sv
// N-channel push-button conditioner: independent pb_chan instances plus a
// registered any-event flag summarising last cycle's pulses.
module pb_edge_multi
   import pb_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYC     = 1000000,
   parameter int LONG_CYC    = 100000000,
   parameter int REP_CYC     = 25000000,
   parameter bit ACTIVE_LOW  = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] pb,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] prss,
   output logic [N_CH-1:0] rls,
   output logic [N_CH-1:0] lng,
   output logic [N_CH-1:0] rpt,
   output logic            evt_any
);

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      pb_chan #(
         .SYNC_STAGES(SYNC_STAGES),
         .DEB_CYC    (DEB_CYC),
         .LONG_CYC   (LONG_CYC),
         .REP_CYC    (REP_CYC),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_chan (
         .clk  (clk),
         .rst  (rst),
         .pb   (pb[i]),
         .level(level[i]),
         .prss (prss[i]),
         .rls  (rls[i]),
         .lng  (lng[i]),
         .rpt  (rpt[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) evt_any <= 1'b0;
      else     evt_any <= |(prss | rls | lng | rpt);
   end

endmodule

// File: tb/tb_pb_edge_multi.sv
// Directed bench for pb_edge_multi: an active-high and an active-low instance
// see the same logical stimulus and are compared every cycle to hand-derived vectors.
module tb_pb_edge_multi;

   localparam int N_CH = 4;
   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int LONG = 16;
   localparam int REP  = 8;

   // Bit positions inside the observed vector {evt, level, prss, rls, lng, rpt}.
   localparam int E = 20;
   localparam int L = 16;
   localparam int P = 12;
   localparam int R = 8;
   localparam int G = 4;
   localparam int Q = 0;

   logic            clk = 1'b0;
   logic            rst;
   logic [N_CH-1:0] pb;
   logic [N_CH-1:0] pb_n;
   logic [N_CH-1:0] level_h, prss_h, rls_h, lng_h, rpt_h;
   logic [N_CH-1:0] level_l, prss_l, rls_l, lng_l, rpt_l;
   logic            evt_h, evt_l;
   logic [20:0]     obs_h, obs_l;
   int              total = 0;
   int              bad   = 0;

   always #5 clk = ~clk;

   assign pb_n  = ~pb;
   assign obs_h = {evt_h, level_h, prss_h, rls_h, lng_h, rpt_h};
   assign obs_l = {evt_l, level_l, prss_l, rls_l, lng_l, rpt_l};

   pb_edge_multi #(
      .N_CH(N_CH), .SYNC_STAGES(SYNC), .DEB_CYC(DEB),
      .LONG_CYC(LONG), .REP_CYC(REP), .ACTIVE_LOW(1'b0)
   ) dut_hi (
      .clk(clk), .rst(rst), .pb(pb),
      .level(level_h), .prss(prss_h), .rls(rls_h), .lng(lng_h), .rpt(rpt_h),
      .evt_any(evt_h)
   );

   pb_edge_multi #(
      .N_CH(N_CH), .SYNC_STAGES(SYNC), .DEB_CYC(DEB),
      .LONG_CYC(LONG), .REP_CYC(REP), .ACTIVE_LOW(1'b1)
   ) dut_lo (
      .clk(clk), .rst(rst), .pb(pb_n),
      .level(level_l), .prss(prss_l), .rls(rls_l), .lng(lng_l), .rpt(rpt_l),
      .evt_any(evt_l)
   );

   // t counts edges from the first edge that samples the new stimulus.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [20:0] exp;
      rst = 1'b1;
      pb  = '0;
      for (int t = 0; t < 7; t++) begin
         if (t == 3) rst = 1'b0;
         tick();
         exp = '0;
         total++;
         if (obs_h !== exp) begin
            bad++;
            $display("FAIL reset t=%0d hi got=%h want=%h", t, obs_h, exp);
         end
         total++;
         if (obs_l !== exp) begin
            bad++;
            $display("FAIL reset t=%0d lo got=%h want=%h", t, obs_l, exp);
         end
      end
   endtask

   // ch0 held 10 cycles: prss at 6, rls 6 after release, no lng.
   task automatic test_clean_press();
      logic [20:0] exp;
      for (int t = 0; t < 20; t++) begin
         pb[0] = (t < 10);
         tick();
         exp      = '0;
         exp[E]   = (t == 7) || (t == 17);
         exp[L+0] = (t >= 6) && (t < 16);
         exp[P+0] = (t == 6);
         exp[R+0] = (t == 16);
         total++;
         if (obs_h !== exp) begin
            bad++;
            $display("FAIL clean_press t=%0d hi got=%h want=%h", t, obs_h, exp);
         end
         total++;
         if (obs_l !== exp) begin
            bad++;
            $display("FAIL clean_press t=%0d lo got=%h want=%h", t, obs_l, exp);
         end
      end
   endtask

   // ch1 bounces 1-0-1-0, settles high from t=4: single prss at 10.
   task automatic test_bounce();
      logic [20:0] exp;
      for (int t = 0; t < 25; t++) begin
         pb[1] = (t == 0) || (t == 2) || ((t >= 4) && (t < 15));
         tick();
         exp      = '0;
         exp[E]   = (t == 11) || (t == 22);
         exp[L+1] = (t >= 10) && (t < 21);
         exp[P+1] = (t == 10);
         exp[R+1] = (t == 21);
         total++;
         if (obs_h !== exp) begin
            bad++;
            $display("FAIL bounce t=%0d hi got=%h want=%h", t, obs_h, exp);
         end
         total++;
         if (obs_l !== exp) begin
            bad++;
            $display("FAIL bounce t=%0d lo got=%h want=%h", t, obs_l, exp);
         end
      end
   endtask

   // ch2 long hold: prss 6, lng 22, rpt 30/38/46/54, rls 64.
   task automatic test_long_repeat();
      logic [20:0] exp;
      for (int t = 0; t < 68; t++) begin
         pb[2] = (t < 58);
         tick();
         exp      = '0;
         exp[E]   = (t == 7) || (t == 23) || (t == 31) || (t == 39) ||
                    (t == 47) || (t == 55) || (t == 65);
         exp[L+2] = (t >= 6) && (t < 64);
         exp[P+2] = (t == 6);
         exp[G+2] = (t == 22);
         exp[Q+2] = (t == 30) || (t == 38) || (t == 46) || (t == 54);
         exp[R+2] = (t == 64);
         total++;
         if (obs_h !== exp) begin
            bad++;
            $display("FAIL long_repeat t=%0d hi got=%h want=%h", t, obs_h, exp);
         end
         total++;
         if (obs_l !== exp) begin
            bad++;
            $display("FAIL long_repeat t=%0d lo got=%h want=%h", t, obs_l, exp);
         end
      end
   endtask

   // 2-cycle release glitch on ch2 while held: no rls, lng slips from 22 to 24.
   task automatic test_glitch();
      logic [20:0] exp;
      for (int t = 0; t < 38; t++) begin
         pb[2] = (t != 10) && (t != 11) && (t < 28);
         tick();
         exp      = '0;
         exp[E]   = (t == 7) || (t == 25) || (t == 35);
         exp[L+2] = (t >= 6) && (t < 34);
         exp[P+2] = (t == 6);
         exp[G+2] = (t == 24);
         exp[R+2] = (t == 34);
         total++;
         if (obs_h !== exp) begin
            bad++;
            $display("FAIL glitch t=%0d hi got=%h want=%h", t, obs_h, exp);
         end
         total++;
         if (obs_l !== exp) begin
            bad++;
            $display("FAIL glitch t=%0d lo got=%h want=%h", t, obs_l, exp);
         end
      end
   endtask

   // ch0 and ch3 pressed together: pulses coincide, evt_any one cycle later.
   task automatic test_back_to_back();
      logic [20:0] exp;
      for (int t = 0; t < 18; t++) begin
         pb[0] = (t < 8);
         pb[3] = (t < 8);
         tick();
         exp      = '0;
         exp[E]   = (t == 7) || (t == 15);
         exp[L+0] = (t >= 6) && (t < 14);
         exp[L+3] = (t >= 6) && (t < 14);
         exp[P+0] = (t == 6);
         exp[P+3] = (t == 6);
         exp[R+0] = (t == 14);
         exp[R+3] = (t == 14);
         total++;
         if (obs_h !== exp) begin
            bad++;
            $display("FAIL simultaneous t=%0d hi got=%h want=%h", t, obs_h, exp);
         end
         total++;
         if (obs_l !== exp) begin
            bad++;
            $display("FAIL simultaneous t=%0d lo got=%h want=%h", t, obs_l, exp);
         end
      end
   endtask

   // Reset for 3 cycles mid-hold on ch1: outputs clear, no rls, fresh prss 6 after release.
   task automatic test_reset_mid_hold();
      logic [20:0] exp;
      for (int t = 0; t < 35; t++) begin
         pb[1] = (t < 25);
         rst   = (t >= 10) && (t < 13);
         tick();
         exp      = '0;
         exp[E]   = (t == 7) || (t == 20) || (t == 32);
         exp[L+1] = ((t >= 6) && (t < 10)) || ((t >= 19) && (t < 31));
         exp[P+1] = (t == 6) || (t == 19);
         exp[R+1] = (t == 31);
         total++;
         if (obs_h !== exp) begin
            bad++;
            $display("FAIL reset_mid_hold t=%0d hi got=%h want=%h", t, obs_h, exp);
         end
         total++;
         if (obs_l !== exp) begin
            bad++;
            $display("FAIL reset_mid_hold t=%0d lo got=%h want=%h", t, obs_l, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_repeat();
      test_glitch();
      test_back_to_back();
      test_reset_mid_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
